kcpsmx_writeback: RTL
=====================

KCPSMX_WRITEBACK -- requirements
Module: kcpsmx_writeback

Interface
REQ-001 The block SHALL expose parameter OPERAND_WIDTH, default 8, meaning register data width.
REQ-002 The block SHALL expose parameter REG_ADDR_WIDTH, default 4, meaning register-file address width (16 registers).
REQ-003 clk  input  1  single clock; all state changes on posedge.
REQ-004 reset_n  input  1  reset, synchronous, active-low.
REQ-005 ex_valid  input  1  execute-stage instruction valid this cycle.
REQ-006 ex_operation  input  opcode_t  opcode of executing instruction (kcpsmx3_inc).
REQ-007 ex_dest  input  REG_ADDR_WIDTH  destination register (sX).
REQ-008 alu_result / alu_zero / alu_carry  input  OPERAND_WIDTH / 1 / 1  ALU outputs for the executing instruction.
REQ-009 stall, flush  input  1 each  pipeline hold; kill of executing instruction.
REQ-010 int_save  input  1  interrupt accepted: copy flags to shadow.
REQ-011 int_restore  input  1  RETURNI: reload flags from shadow.
REQ-012 wb_we, wb_addr, wb_data  output  1 / REG_ADDR_WIDTH / OPERAND_WIDTH  registered register-file write port.
REQ-013 flag_zero, flag_carry  output  1 each  architectural Z and C flags (registered).
REQ-014 fwd_valid, fwd_addr, fwd_data  output  1 / REG_ADDR_WIDTH / OPERAND_WIDTH  bypass of the writeback stage to decode, equal to wb_we/wb_addr/wb_data.

Function
REQ-015 An instruction SHALL be accepted on a posedge when ex_valid=1, stall=0, flush=0; otherwise it SHALL be dropped (bubble).
REQ-016 Latency SHALL be one cycle: an accepted instruction's write appears on wb_* in the cycle after acceptance, for exactly one cycle.
REQ-017 wb_we SHALL be 1 after acceptance of ADD, ADDCY, SUB, SUBCY, AND, OR, XOR, RS, LOAD, INPUT; 0 for COMPARE, TEST and all other opcodes.
REQ-018 wb_data SHALL equal alu_result and wb_addr ex_dest as sampled at acceptance; both SHALL hold their last value when wb_we=0.
REQ-019 Flags SHALL update at acceptance for ADD, ADDCY, SUB, SUBCY, COMPARE, AND, OR, XOR, TEST, RS: flag_zero<=alu_zero, flag_carry<=alu_carry.
REQ-020 Flags SHALL be unchanged for all other opcodes, for bubbles, stalled and flushed cycles.
REQ-021 int_save SHALL load shadow_z/shadow_c with the flag values as they are after the same edge (i.e. including an update by an instruction accepted that cycle).
REQ-022 int_restore SHALL load flags from shadow at that edge and SHALL take priority over any flag update from an instruction accepted the same cycle; that instruction's register write still occurs.
REQ-023 int_save and int_restore asserted together SHALL perform restore only; shadow unchanged.
REQ-024 stall with flush asserted together SHALL behave as flush (bubble).
REQ-025 Block SHALL contain no combinational path from inputs to any output.

Reset
REQ-026 On a posedge with reset_n=0: wb_we=0, wb_addr=0, wb_data=0, flag_zero=0, flag_carry=0, shadow flags=0, fwd_valid=0; reset overrides all other inputs including int_restore.
REQ-027 An instruction presented on the reset edge SHALL be discarded; first acceptance is possible on the first edge with reset_n=1.

Verification
REQ-028 ADD, ex_dest=3, alu_result=8'h00, alu_zero=1, alu_carry=1, accepted -> next cycle wb_we=1, wb_addr=3, wb_data=00, Z=1, C=1.
REQ-029 COMPARE with alu_zero=0, alu_carry=1 then LOAD with alu_result=8'h5A -> COMPARE: wb_we=0, Z=0, C=1; LOAD: wb_we=1, wb_data=5A, flags still Z=0, C=1.
REQ-030 Flags Z=1,C=0; int_save with XOR accepted (alu_zero=0, alu_carry=0); later SUB sets Z=0,C=1; int_restore -> flags Z=0,C=0 (post-XOR values).
REQ-031 int_restore same edge as ADD (alu_zero=1, alu_carry=1), shadow Z=0,C=1 -> flags Z=0,C=1, wb_we=1 next cycle.
REQ-032 ex_valid=1 with stall=1, then with flush=1 -> wb_we=0 both following cycles, flags unchanged.
REQ-033 reset_n=0 during accepted ADD with prior flags Z=1,C=1 -> next cycle all outputs 0, shadow 0.

Source files
------------

// File: rtl/kcpsmx_writeback.sv
// KCPSMx writeback stage: registered register-file write port, Z/C flags,
// interrupt flag shadow and decode bypass.
//
// Ports:
//   clk, reset_n         clock; synchronous active-low reset
//   ex_valid             execute-stage instruction valid
//   ex_operation         opcode of the executing instruction
//   ex_dest              destination register sX
//   alu_result           ALU data result
//   alu_zero, alu_carry  ALU flag results
//   stall, flush         pipeline hold / kill of executing instruction
//   int_save             interrupt accepted: copy flags to shadow
//   int_restore          RETURNI: reload flags from shadow
//   wb_we/addr/data      registered register-file write port
//   flag_zero/carry      architectural Z and C flags
//   fwd_valid/addr/data  bypass to decode (mirror of wb_*)

package kcpsmx3_inc;

  typedef enum logic [4:0] {
    OP_NOP     = 5'd0,
    OP_LOAD    = 5'd1,
    OP_AND     = 5'd2,
    OP_OR      = 5'd3,
    OP_XOR     = 5'd4,
    OP_ADD     = 5'd5,
    OP_ADDCY   = 5'd6,
    OP_SUB     = 5'd7,
    OP_SUBCY   = 5'd8,
    OP_TEST    = 5'd9,
    OP_COMPARE = 5'd10,
    OP_RS      = 5'd11,
    OP_INPUT   = 5'd12,
    OP_OUTPUT  = 5'd13,
    OP_STORE   = 5'd14,
    OP_FETCH   = 5'd15,
    OP_JUMP    = 5'd16,
    OP_CALL    = 5'd17,
    OP_RETURN  = 5'd18,
    OP_RETURNI = 5'd19,
    OP_ENINT   = 5'd20,
    OP_DISINT  = 5'd21
  } opcode_t;

  localparam int unsigned OP_COUNT = 22;

endpackage

module kcpsmx_writeback
  import kcpsmx3_inc::*;
#(
  parameter int OPERAND_WIDTH  = 8,
  parameter int REG_ADDR_WIDTH = 4
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      ex_valid,
  input  opcode_t                   ex_operation,
  input  logic [REG_ADDR_WIDTH-1:0] ex_dest,
  input  logic [OPERAND_WIDTH-1:0]  alu_result,
  input  logic                      alu_zero,
  input  logic                      alu_carry,
  input  logic                      stall,
  input  logic                      flush,
  input  logic                      int_save,
  input  logic                      int_restore,
  output logic                      wb_we,
  output logic [REG_ADDR_WIDTH-1:0] wb_addr,
  output logic [OPERAND_WIDTH-1:0]  wb_data,
  output logic                      flag_zero,
  output logic                      flag_carry,
  output logic                      fwd_valid,
  output logic [REG_ADDR_WIDTH-1:0] fwd_addr,
  output logic [OPERAND_WIDTH-1:0]  fwd_data
);

  logic                      we_q, we_d;
  logic [REG_ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [OPERAND_WIDTH-1:0]  data_q, data_d;
  logic                      z_q, z_d;
  logic                      c_q, c_d;
  logic                      sz_q, sz_d;
  logic                      sc_q, sc_d;

  logic accept;
  logic op_wr;
  logic op_fl;
  logic z_upd;
  logic c_upd;

  // flush wins over stall: either one turns the slot into a bubble
  assign accept = ex_valid & ~stall & ~flush;

  always_comb begin
    op_wr = 1'b0;
    op_fl = 1'b0;
    case (ex_operation)
      OP_ADD,
      OP_ADDCY,
      OP_SUB,
      OP_SUBCY,
      OP_AND,
      OP_OR,
      OP_XOR,
      OP_RS: begin
        op_wr = 1'b1;
        op_fl = 1'b1;
      end
      OP_LOAD,
      OP_INPUT: begin
        op_wr = 1'b1;
      end
      OP_COMPARE,
      OP_TEST: begin
        op_fl = 1'b1;
      end
      default: begin
        op_wr = 1'b0;
        op_fl = 1'b0;
      end
    endcase
  end

  always_comb begin
    we_d   = accept & op_wr;
    addr_d = addr_q;
    data_d = data_q;
    if (accept && op_wr) begin
      addr_d = ex_dest;
      data_d = alu_result;
    end
  end

  // z_upd/c_upd are the flags after this edge's instruction; restore
  // overrides them, and save captures them (so a save sees an update
  // made by the instruction accepted on the same edge).
  always_comb begin
    z_upd = z_q;
    c_upd = c_q;
    if (accept && op_fl) begin
      z_upd = alu_zero;
      c_upd = alu_carry;
    end
    z_d  = z_upd;
    c_d  = c_upd;
    sz_d = sz_q;
    sc_d = sc_q;
    if (int_restore) begin
      z_d = sz_q;
      c_d = sc_q;
    end else if (int_save) begin
      sz_d = z_upd;
      sc_d = c_upd;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      we_q   <= 1'b0;
      addr_q <= '0;
      data_q <= '0;
      z_q    <= 1'b0;
      c_q    <= 1'b0;
      sz_q   <= 1'b0;
      sc_q   <= 1'b0;
    end else begin
      we_q   <= we_d;
      addr_q <= addr_d;
      data_q <= data_d;
      z_q    <= z_d;
      c_q    <= c_d;
      sz_q   <= sz_d;
      sc_q   <= sc_d;
    end
  end

  assign wb_we      = we_q;
  assign wb_addr    = addr_q;
  assign wb_data    = data_q;
  assign flag_zero  = z_q;
  assign flag_carry = c_q;
  assign fwd_valid  = we_q;
  assign fwd_addr   = addr_q;
  assign fwd_data   = data_q;

endmodule
